// File: rtl/lsu_arbiter_if.sv
// lsu_arbiter_if: two requester ports plus the LSU-side bus of the LSU arbiter.
interface lsu_arbiter_if;
    logic        i_m0_req, i_m1_req;
    logic        i_m0_we, i_m1_we;
    logic [2:0]  i_m0_funct3, i_m1_funct3;
    logic [31:0] i_m0_addr, i_m1_addr;
    logic [31:0] i_m0_wdata, i_m1_wdata;
    logic        i_m0_lock, i_m1_lock;
    logic        o_m0_gnt, o_m1_gnt;
    logic        o_m0_rvalid, o_m1_rvalid;
    logic [31:0] o_m0_rdata, o_m1_rdata;
    logic [31:0] o_lsu_addr, o_lsu_st_data;
    logic [2:0]  o_lsu_funct3;
    logic        o_lsu_wren;
    logic [31:0] i_ld_data;

    modport master (
        output i_m0_req, i_m1_req, i_m0_we, i_m1_we, i_m0_funct3, i_m1_funct3,
               i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata, i_m0_lock, i_m1_lock, i_ld_data,
        input  o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
               o_lsu_addr, o_lsu_st_data, o_lsu_funct3, o_lsu_wren
    );

    modport slave (
        input  i_m0_req, i_m1_req, i_m0_we, i_m1_we, i_m0_funct3, i_m1_funct3,
               i_m0_addr, i_m1_addr, i_m0_wdata, i_m1_wdata, i_m0_lock, i_m1_lock, i_ld_data,
        output o_m0_gnt, o_m1_gnt, o_m0_rvalid, o_m1_rvalid, o_m0_rdata, o_m1_rdata,
               o_lsu_addr, o_lsu_st_data, o_lsu_funct3, o_lsu_wren
    );
endinterface

// File: rtl/lsu_arbiter.sv
// lsu_arbiter: two-port round-robin arbiter in front of the LSU, one transaction per ARB+XFER pair.
// Define LSU_ARB_LOCK_EN to let a locked port keep winning for up to MAX_LOCK grants.
module lsu_arbiter #(
    parameter int MAX_LOCK = 8
) (
    input logic          i_clk,
    input logic          i_reset,
    lsu_arbiter_if.slave bus
);
    typedef enum logic {ARB, XFER} state_t;
    state_t state, state_n;
    logic win, win_n, last, any_req, rr_win;
    logic we_q;
    logic [2:0] f3_q;
    logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
    logic [1:0] rvalid_q;
    assign any_req = bus.i_m0_req | bus.i_m1_req;
    assign rr_win = (bus.i_m0_req & bus.i_m1_req) ? ~last : bus.i_m1_req;
`ifdef LSU_ARB_LOCK_EN
    logic [3:0] lock_cnt;
    logic lock_port, lock_hold, win_lock;
    // A nonzero count means the previous grant was locked; reaching MAX_LOCK forces one round-robin pick.
    assign lock_hold = lock_cnt != 4'd0 && lock_cnt < 4'(MAX_LOCK) && (lock_port ? bus.i_m1_req : bus.i_m0_req);
    assign win_lock = win ? bus.i_m1_lock : bus.i_m0_lock;
    assign win_n = lock_hold ? lock_port : rr_win;
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            lock_cnt <= 4'd0;
            lock_port <= 1'b0;
        end else if (state == ARB && lock_cnt == 4'(MAX_LOCK)) begin
            lock_cnt <= 4'd0;
        end else if (state == XFER) begin
            lock_port <= win;
            lock_cnt <= win_lock ? ((win == lock_port && lock_cnt != 4'd0) ? lock_cnt + 4'd1 : 4'd1) : 4'd0;
        end
`else
    logic unused_lock;
    assign unused_lock = bus.i_m0_lock ^ bus.i_m1_lock;
    assign win_n = rr_win;
`endif
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) state <= ARB;
        else state <= state_n;
    always_comb begin
        state_n = ARB;
        if (state == ARB && any_req) state_n = XFER;
    end
    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            win <= 1'b0;
            last <= 1'b1;
            we_q <= 1'b0;
            f3_q <= 3'd0;
            addr_q <= 32'd0;
            wdata_q <= 32'd0;
            rvalid_q <= 2'b00;
            rdata0_q <= 32'd0;
            rdata1_q <= 32'd0;
        end else begin
            rvalid_q <= 2'b00;
            if (state == ARB && any_req) begin
                win <= win_n;
                we_q <= win_n ? bus.i_m1_we : bus.i_m0_we;
                f3_q <= win_n ? bus.i_m1_funct3 : bus.i_m0_funct3;
                addr_q <= win_n ? bus.i_m1_addr : bus.i_m0_addr;
                wdata_q <= win_n ? bus.i_m1_wdata : bus.i_m0_wdata;
            end
            if (state == XFER) begin
                last <= win;
                if (!we_q) begin
                    rvalid_q[win] <= 1'b1;
                    if (win) rdata1_q <= bus.i_ld_data;
                    else rdata0_q <= bus.i_ld_data;
                end
            end
        end
    assign bus.o_m0_gnt = state == XFER && !win;
    assign bus.o_m1_gnt = state == XFER && win;
    assign bus.o_m0_rvalid = rvalid_q[0];
    assign bus.o_m1_rvalid = rvalid_q[1];
    assign bus.o_m0_rdata = rdata0_q;
    assign bus.o_m1_rdata = rdata1_q;
    // Combinational gating lets an async reset drop the LSU strobes immediately.
    assign bus.o_lsu_wren = state == XFER && we_q;
    assign bus.o_lsu_addr = state == XFER ? addr_q : 32'd0;
    assign bus.o_lsu_funct3 = state == XFER ? f3_q : 3'd0;
    assign bus.o_lsu_st_data = state == XFER ? wdata_q : 32'd0;
endmodule

// File: tb/tb_lsu_arbiter.sv
// tb_lsu_arbiter: directed self-checking bench for lsu_arbiter.
module tb_lsu_arbiter;
    logic i_clk = 1'b0;
    logic i_reset = 1'b0;
    int checks = 0;
    int failures = 0;
    lsu_arbiter_if bus ();
    lsu_arbiter #(.MAX_LOCK(8)) dut (.i_clk(i_clk), .i_reset(i_reset), .bus(bus));
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        bus.i_m0_req = 0; bus.i_m1_req = 0; bus.i_m0_we = 0; bus.i_m1_we = 0;
        bus.i_m0_funct3 = 0; bus.i_m1_funct3 = 0; bus.i_m0_addr = 0; bus.i_m1_addr = 0;
        bus.i_m0_wdata = 0; bus.i_m1_wdata = 0; bus.i_m0_lock = 0; bus.i_m1_lock = 0;
        bus.i_ld_data = 0;
        step();
        chk("rst_gnt", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd0);
        chk("rst_rvalid", {30'd0, bus.o_m1_rvalid, bus.o_m0_rvalid}, 32'd0);
        chk("rst_wren", {31'd0, bus.o_lsu_wren}, 32'd0);
        chk("rst_addr", bus.o_lsu_addr, 32'd0);
        chk("rst_rdata0", bus.o_m0_rdata, 32'd0);
        // m0 load
        i_reset = 1;
        bus.i_m0_req = 1; bus.i_m0_funct3 = 3'b010; bus.i_m0_addr = 32'h10; bus.i_ld_data = 32'hDEADBEEF;
        step();
        chk("lw_gnt", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd1);
        chk("lw_addr", bus.o_lsu_addr, 32'h10);
        chk("lw_wren", {31'd0, bus.o_lsu_wren}, 32'd0);
        chk("lw_funct3", {29'd0, bus.o_lsu_funct3}, 32'd2);
        bus.i_m0_req = 0;
        step();
        chk("lw_rvalid", {30'd0, bus.o_m1_rvalid, bus.o_m0_rvalid}, 32'd1);
        chk("lw_rdata", bus.o_m0_rdata, 32'hDEADBEEF);
        chk("lw_idle_addr", bus.o_lsu_addr, 32'd0);
        // m1 store
        bus.i_m1_req = 1; bus.i_m1_we = 1; bus.i_m1_funct3 = 3'b010;
        bus.i_m1_addr = 32'h20; bus.i_m1_wdata = 32'h12345678; bus.i_ld_data = 32'hCAFEF00D;
        step();
        chk("sw_gnt", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd2);
        chk("sw_wren", {31'd0, bus.o_lsu_wren}, 32'd1);
        chk("sw_data", bus.o_lsu_st_data, 32'h12345678);
        chk("sw_addr", bus.o_lsu_addr, 32'h20);
        chk("sw_funct3", {29'd0, bus.o_lsu_funct3}, 32'd2);
        bus.i_m1_req = 0;
        step();
        chk("sw_no_rvalid", {30'd0, bus.o_m1_rvalid, bus.o_m0_rvalid}, 32'd0);
        chk("sw_wren_idle", {31'd0, bus.o_lsu_wren}, 32'd0);
        chk("rdata0_hold", bus.o_m0_rdata, 32'hDEADBEEF);
        chk("rdata1_hold", bus.o_m1_rdata, 32'd0);
        // both ports loading continuously: alternation starting at port 0
        bus.i_m1_we = 0; bus.i_m0_addr = 32'h100; bus.i_m1_addr = 32'h200;
        bus.i_m0_req = 1; bus.i_m1_req = 1;
        for (int i = 0; i < 8; i++) begin
            bus.i_ld_data = 32'hA000 + i;
            step();
            chk($sformatf("rr_gnt%0d", i), {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, (i % 2) ? 32'd2 : 32'd1);
            chk($sformatf("rr_addr%0d", i), bus.o_lsu_addr, (i % 2) ? 32'h200 : 32'h100);
            step();
            chk($sformatf("rr_idle%0d", i), {28'd0, bus.o_m1_gnt, bus.o_m0_gnt, bus.o_m1_rvalid, bus.o_m0_rvalid},
                (i % 2) ? 32'd2 : 32'd1);
            chk($sformatf("rr_rdata%0d", i), (i % 2) ? bus.o_m1_rdata : bus.o_m0_rdata, 32'hA000 + i);
        end
        // reset in the middle of a store's XFER
        bus.i_m1_req = 0; bus.i_m0_we = 1; bus.i_m0_wdata = 32'h55AA55AA;
        step();
        chk("mid_wren", {31'd0, bus.o_lsu_wren}, 32'd1);
        #2 i_reset = 0;
        #1;
        chk("async_wren", {31'd0, bus.o_lsu_wren}, 32'd0);
        chk("async_gnt", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd0);
        chk("async_rdata0", bus.o_m0_rdata, 32'd0);
        step();
        i_reset = 1; bus.i_m0_we = 0; bus.i_m1_req = 1;
        step();
        chk("post_rst_tie", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd1);
        step();
        // m1 locked, both requesting; last grant was port 0 so port 1 wins the first tie
        bus.i_m1_lock = 1;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] e;
`ifdef LSU_ARB_LOCK_EN
            e = (i == 8) ? 32'd1 : 32'd2;
`else
            e = (i % 2) ? 32'd1 : 32'd2;
`endif
            step();
            chk($sformatf("lock_gnt%0d", i), {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, e);
            step();
        end
        bus.i_m0_req = 0; bus.i_m1_req = 0;
        step();
        chk("final_idle", {30'd0, bus.o_m1_gnt, bus.o_m0_gnt}, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
